t03_text_banner: RTL and testbench



---
 rtl/t03_text_banner.sv | 242 ++++++++++++++++++++++++
 tb/tb_t03_text_banner.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/t03_text_banner.sv
// HUD text-banner engine: fixed strings per game state, or both players' health as
// blanked decimal (sequential double-dabble), with optional marquee rotation and win-screen blink.
module t03_text_banner #(
  parameter int unsigned NCHARS       = 12,
  parameter int unsigned CHAR_W       = 6,
  parameter int unsigned HP_W         = 12,
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCROLL_TICKS = 8,
  parameter int unsigned BLINK_TICKS  = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_tick,
  input  logic [2:0]               game_state,
  input  logic [HP_W-1:0]          p1health,
  input  logic [HP_W-1:0]          p2health,
  input  logic                     scroll_en,
  output logic [NCHARS*CHAR_W-1:0] alphabet,
  output logic [7:0]               text_color,
  output logic                     text_valid
);
  localparam int unsigned AW    = NCHARS * CHAR_W;
  localparam int unsigned BW    = 4 * DIGITS;
  localparam int unsigned OFF_W = $clog2(NCHARS);
  localparam int unsigned SC_W  = $clog2(SCROLL_TICKS + 1);
  localparam int unsigned BL_W  = $clog2(BLINK_TICKS + 1);
  localparam int unsigned CNT_W = $clog2(HP_W + 1);
  localparam logic [63:0] MAXV  = 64'(10 ** DIGITS - 1);
  localparam logic [CHAR_W-1:0] BLANK = CHAR_W'(37);

  typedef enum logic [1:0] {IDLE, CONV_P1, CONV_P2, UPDATE} conv_state_t;

  function automatic logic [CHAR_W-1:0] enc(input logic [7:0] c);
    logic [7:0] v;
    if (c == 8'h20)      v = 8'd37;
    else if (c <= 8'h39) v = c - 8'h30;
    else                 v = c - 8'd55;
    return v[CHAR_W-1:0];
  endfunction

  function automatic logic [AW-1:0] banner(input logic [95:0] s);
    logic [AW-1:0] r;
    r = {NCHARS{BLANK}};
    for (int unsigned i = 0; i < 12; i++)
      r[(NCHARS-1-i)*CHAR_W +: CHAR_W] = enc(s[(11-i)*8 +: 8]);
    return r;
  endfunction

  function automatic logic [AW-1:0] text_of(input logic [2:0] gs);
    case (gs)
      3'd0:    return banner("FIGHTERS    ");
      3'd1:    return banner("READY       ");
      3'd2:    return banner("GO          ");
      3'd3:    return banner("PAUSE       ");
      3'd5:    return banner("P1 WINS     ");
      3'd6:    return banner("P2 WINS     ");
      default: return banner("            ");
    endcase
  endfunction

  function automatic logic [7:0] color_of(input logic [2:0] gs);
    case (gs)
      3'd1:      return 8'h58;
      3'd2:      return 8'hFC;
      3'd3, 3'd5: return 8'hE4;
      3'd6:      return 8'h07;
      default:   return 8'hFF;
    endcase
  endfunction

  // Most-significant digit lands leftmost; blanking stops at the first nonzero or the units digit.
  function automatic logic [DIGITS*CHAR_W-1:0] fmt(input logic [BW-1:0] bcd, input logic sat);
    logic [DIGITS*CHAR_W-1:0] r;
    logic                     seen;
    logic [3:0]               d;
    r    = '0;
    seen = 1'b0;
    for (int unsigned k = DIGITS; k > 0; k--) begin
      d = sat ? 4'd9 : bcd[(k-1)*4 +: 4];
      if (d != 4'd0 || k == 1) seen = 1'b1;
      r[(k-1)*CHAR_W +: CHAR_W] = seen ? CHAR_W'(d) : BLANK;
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] rotate(input logic [AW-1:0] a, input logic [OFF_W-1:0] off);
    logic [AW-1:0] r;
    int unsigned   idx;
    r = '0;
    for (int unsigned i = 0; i < NCHARS; i++) begin
      idx = i + 32'(off);
      if (idx >= NCHARS) idx = idx - NCHARS;
      r[(NCHARS-1-i)*CHAR_W +: CHAR_W] = a[(NCHARS-1-idx)*CHAR_W +: CHAR_W];
    end
    return r;
  endfunction

  conv_state_t       st_q, st_d;
  logic [2:0]        prev_q, prev_d;
  logic [AW-1:0]     base_q, base_d, alphabet_q, alphabet_d;
  logic [7:0]        col_q, col_d, text_color_q, text_color_d;
  logic              valid_q, valid_d, blink_q, blink_d, abort_q, abort_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [SC_W-1:0]   scnt_q, scnt_d;
  logic [BL_W-1:0]   bcnt_q, bcnt_d;
  logic [HP_W-1:0]   last_p1_q, last_p1_d, last_p2_q, last_p2_d;
  logic [HP_W-1:0]   bin_q, bin_d, hp2_q, hp2_d;
  logic [BW-1:0]     bcd_q, bcd_d, p1_bcd_q, p1_bcd_d;
  logic              sat1_q, sat1_d, sat2_q, sat2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]     adj;
  logic [BW+HP_W-1:0] dd;
  logic              start;

  always_comb begin
    st_d = st_q;       prev_d = prev_q;     base_d = base_q;   col_d = col_q;
    valid_d = valid_q; blink_d = blink_q;   abort_d = abort_q; off_d = off_q;
    scnt_d = scnt_q;   bcnt_d = bcnt_q;     last_p1_d = last_p1_q; last_p2_d = last_p2_q;
    bin_d = bin_q;     hp2_d = hp2_q;       bcd_d = bcd_q;     p1_bcd_d = p1_bcd_q;
    sat1_d = sat1_q;   sat2_d = sat2_q;     cnt_d = cnt_q;     start = 1'b0;

    for (int unsigned d = 0; d < DIGITS; d++)
      adj[d*4 +: 4] = (bcd_q[d*4 +: 4] >= 4'd5) ? bcd_q[d*4 +: 4] + 4'd3 : bcd_q[d*4 +: 4];
    dd = {adj, bin_q} << 1;

    if (!scroll_en) begin
      off_d  = '0;
      scnt_d = '0;
    end else if (frame_tick) begin
      if (scnt_q == SC_W'(SCROLL_TICKS - 1)) begin
        scnt_d = '0;
        off_d  = (off_q == OFF_W'(NCHARS - 1)) ? '0 : off_q + 1'b1;
      end else begin
        scnt_d = scnt_q + 1'b1;
      end
    end

    if (prev_q != 3'd5 && prev_q != 3'd6) begin
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (frame_tick) begin
      if (bcnt_q == BL_W'(BLINK_TICKS - 1)) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end

    case (st_q)
      IDLE: begin
        if (game_state != prev_q) begin
          prev_d  = game_state;
          off_d   = '0;
          scnt_d  = '0;
          bcnt_d  = '0;
          blink_d = 1'b1;
          if (game_state == 3'd4) begin
            valid_d = 1'b0;
            start   = 1'b1;
          end else begin
            base_d  = text_of(game_state);
            col_d   = color_of(game_state);
            valid_d = 1'b1;
          end
        end else if (prev_q == 3'd4 && (p1health != last_p1_q || p2health != last_p2_q)) begin
          start = 1'b1;
        end
        if (start) begin
          st_d      = CONV_P1;
          bin_d     = p1health;
          hp2_d     = p2health;
          last_p1_d = p1health;
          last_p2_d = p2health;
          sat1_d    = 64'(p1health) > MAXV;
          sat2_d    = 64'(p2health) > MAXV;
          bcd_d     = '0;
          cnt_d     = '0;
          abort_d   = 1'b0;
        end
      end
      CONV_P1: begin
        {bcd_d, bin_d} = dd;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(HP_W - 1)) begin
          p1_bcd_d = dd[BW+HP_W-1 -: BW];
          bin_d    = hp2_q;
          bcd_d    = '0;
          cnt_d    = '0;
          st_d     = CONV_P2;
        end
      end
      CONV_P2: begin
        {bcd_d, bin_d} = dd;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(HP_W - 1)) st_d = UPDATE;
      end
      default: begin
        st_d = IDLE;
        // A state change at any point during conversion voids the result; IDLE then takes over.
        if (!abort_q && game_state == prev_q) begin
          base_d = {NCHARS{BLANK}};
          base_d[AW-1 -: DIGITS*CHAR_W]  = fmt(p1_bcd_q, sat1_q);
          base_d[DIGITS*CHAR_W-1:0]      = fmt(bcd_q, sat2_q);
          col_d   = 8'hFF;
          valid_d = 1'b1;
        end
      end
    endcase

    if (st_q != IDLE && game_state != prev_q) abort_d = 1'b1;

    alphabet_d   = rotate(base_d, off_d);
    text_color_d = blink_d ? col_d : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;          prev_q <= 3'd7;
      base_q <= {NCHARS{BLANK}}; alphabet_q <= {NCHARS{BLANK}};
      col_q <= 8'hFF;        text_color_q <= 8'hFF;
      valid_q <= 1'b0;       blink_q <= 1'b1;     abort_q <= 1'b0;
      off_q <= '0;           scnt_q <= '0;        bcnt_q <= '0;
      last_p1_q <= '0;       last_p2_q <= '0;
      bin_q <= '0;           hp2_q <= '0;         bcd_q <= '0;  p1_bcd_q <= '0;
      sat1_q <= 1'b0;        sat2_q <= 1'b0;      cnt_q <= '0;
    end else begin
      st_q <= st_d;          prev_q <= prev_d;
      base_q <= base_d;      alphabet_q <= alphabet_d;
      col_q <= col_d;        text_color_q <= text_color_d;
      valid_q <= valid_d;    blink_q <= blink_d;  abort_q <= abort_d;
      off_q <= off_d;        scnt_q <= scnt_d;    bcnt_q <= bcnt_d;
      last_p1_q <= last_p1_d; last_p2_q <= last_p2_d;
      bin_q <= bin_d;        hp2_q <= hp2_d;      bcd_q <= bcd_d;  p1_bcd_q <= p1_bcd_d;
      sat1_q <= sat1_d;      sat2_q <= sat2_d;    cnt_q <= cnt_d;
    end
  end

  assign alphabet   = alphabet_q;
  assign text_color = text_color_q;
  assign text_valid = valid_q;
endmodule

// File: tb/tb_t03_text_banner.sv
// Directed bench for t03_text_banner: fixed strings, health conversion, scroll, blink, abort and reset.
module tb_t03_text_banner;
  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic [2:0]  game_state;
  logic [11:0] p1health, p2health;
  logic        scroll_en;
  logic [71:0] alphabet;
  logic [7:0]  text_color;
  logic        text_valid;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [5:0] B = 6'd37;
  localparam logic [71:0] S_BLANK = {12{B}};
  localparam logic [71:0] S_FIGHT = {6'd15, 6'd18, 6'd16, 6'd17, 6'd29, 6'd14, 6'd27, 6'd28, {4{B}}};
  localparam logic [71:0] S_HP1   = {6'd1, 6'd2, 6'd3, 6'd4, {7{B}}, 6'd7};
  localparam logic [71:0] S_HP2   = {B, B, B, 6'd0, {7{B}}, 6'd7};
  localparam logic [71:0] S_GO0   = {6'd16, 6'd24, {10{B}}};
  localparam logic [71:0] S_GO1   = {6'd24, {10{B}}, 6'd16};
  localparam logic [71:0] S_GO2   = {{10{B}}, 6'd16, 6'd24};
  localparam logic [71:0] S_P1W   = {6'd25, 6'd1, B, 6'd32, 6'd18, 6'd23, 6'd28, {5{B}}};
  localparam logic [71:0] S_PAUSE = {6'd25, 6'd10, 6'd30, 6'd28, 6'd14, {7{B}}};
  localparam logic [71:0] S_READY = {6'd27, 6'd14, 6'd10, 6'd13, 6'd34, {7{B}}};

  t03_text_banner #(
    .NCHARS(12), .CHAR_W(6), .HP_W(12), .DIGITS(4), .SCROLL_TICKS(8), .BLINK_TICKS(30)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_state(game_state),
    .p1health(p1health), .p2health(p2health), .scroll_en(scroll_en),
    .alphabet(alphabet), .text_color(text_color), .text_valid(text_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change just after a falling edge; outputs are sampled at falling edges.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    cyc(n);
    frame_tick = 1'b0;
  endtask

  initial begin
    int cnt;
    int digits_seen;
    rst = 1'b1; frame_tick = 1'b0; game_state = 3'd0;
    p1health = '0; p2health = '0; scroll_en = 1'b0;
    cyc(3);
    check("rst_alpha", alphabet, S_BLANK);
    check("rst_color", text_color, 8'hFF);
    check("rst_valid", text_valid, 1'b0);

    rst = 1'b0;
    cyc(1);
    check("title_alpha", alphabet, S_FIGHT);
    check("title_color", text_color, 8'hFF);
    check("title_valid", text_valid, 1'b1);

    p1health = 12'd1234; p2health = 12'd7; game_state = 3'd4;
    cnt = 0;
    cyc(1);
    while (text_valid !== 1'b1 && cnt < 60) begin
      cnt++;
      cyc(1);
    end
    check("fight_latency", cnt, 25);
    check("fight_alpha", alphabet, S_HP1);
    check("fight_color", text_color, 8'hFF);

    p1health = 12'd0;
    for (int i = 0; i < 25; i++) begin
      cyc(1);
      check("refresh_valid", text_valid, 1'b1);
      check("refresh_hold", alphabet, S_HP1);
    end
    cyc(1);
    check("refresh_new", alphabet, S_HP2);
    check("refresh_valid_end", text_valid, 1'b1);

    game_state = 3'd2; scroll_en = 1'b1;
    cyc(1);
    check("go_alpha", alphabet, S_GO0);
    check("go_color", text_color, 8'hFC);
    ticks(8);
    check("scroll_1", alphabet, S_GO1);
    ticks(8);
    check("scroll_2", alphabet, S_GO2);
    scroll_en = 1'b0;
    cyc(1);
    check("scroll_off", alphabet, S_GO0);

    game_state = 3'd5;
    cyc(1);
    check("p1w_alpha", alphabet, S_P1W);
    check("p1w_color", text_color, 8'hE4);
    ticks(29);
    check("blink_29", text_color, 8'hE4);
    ticks(1);
    check("blink_off", text_color, 8'h00);
    ticks(30);
    check("blink_on", text_color, 8'hE4);
    ticks(30);
    check("blink_off2", text_color, 8'h00);
    game_state = 3'd3;
    cyc(1);
    check("pause_color", text_color, 8'hE4);
    check("pause_alpha", alphabet, S_PAUSE);
    game_state = 3'd6;
    cyc(1);
    check("p2w_color", text_color, 8'h07);

    game_state = 3'd4;
    cyc(10);
    game_state = 3'd1;
    cnt = 0;
    digits_seen = 0;
    while (text_valid !== 1'b1 && cnt < 60) begin
      cnt++;
      cyc(1);
      if (alphabet === S_HP2) digits_seen++;
    end
    check("abort_wait", cnt, 17);
    check("abort_alpha", alphabet, S_READY);
    check("abort_color", text_color, 8'h58);
    check("abort_nodigits", digits_seen, 0);

    game_state = 3'd4;
    cyc(5);
    rst = 1'b1;
    cyc(1);
    check("rstmid_alpha", alphabet, S_BLANK);
    check("rstmid_valid", text_valid, 1'b0);
    check("rstmid_color", text_color, 8'hFF);
    rst = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
